// File: rtl/puf_challenge_sequencer.sv
// Sequences one RO-PUF evaluation: serial challenge load, REPS measurement
// windows, and a majority vote of the sampled comparator bits.
module puf_challenge_sequencer #(
    parameter int CHAL_W     = 8,
    parameter int WIN_CYCLES = 1024,
    parameter int REPS       = 3,
    localparam int RW        = $clog2(REPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAL_W-1:0] challenge,
    input  logic              ro_bit,
    output logic              busy,
    output logic              sr_in,
    output logic              sr_shift,
    output logic              cnt_clr,
    output logic              ro_en,
    output logic              done,
    output logic              resp,
    output logic [RW-1:0]     resp_ones
);

    localparam int BW = (CHAL_W > 1) ? $clog2(CHAL_W) : 1;
    localparam int WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_MEASURE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CHAL_W-1:0]   r_shreg;
    logic [BW-1:0]       r_bit_cnt;
    logic [WW-1:0]       r_win_cnt;
    logic [RW-1:0]       r_rep_cnt;
    logic [RW-1:0]       r_ones;
    logic                r_busy;
    logic                r_sr_in;
    logic                r_sr_shift;
    logic                r_cnt_clr;
    logic                r_ro_en;
    logic                r_done;
    logic                r_resp;
    logic [RW-1:0]       r_resp_ones;

    logic                w_abort;
    logic                w_last_bit;
    logic                w_last_win;
    logic                w_last_rep;
    logic [RW-1:0]       w_ones_nxt;
    logic                w_resp_nxt;

    // DONE is past the point of no return, so abort only bites earlier
    assign w_abort    = abort && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_last_bit = (r_bit_cnt == BW'(CHAL_W - 1));
    assign w_last_win = (r_win_cnt == WW'(WIN_CYCLES - 1));
    assign w_last_rep = (r_rep_cnt == RW'(REPS - 1));
    assign w_ones_nxt = r_ones + RW'(ro_bit);
    // 2*ones > REPS, ties fall to 0
    assign w_resp_nxt = ({w_ones_nxt, 1'b0} > (RW + 1)'(REPS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_win_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_ones      <= '0;
            r_busy      <= 1'b0;
            r_sr_in     <= 1'b0;
            r_sr_shift  <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_ro_en     <= 1'b0;
            r_done      <= 1'b0;
            r_resp      <= 1'b0;
            r_resp_ones <= '0;
        end else if (w_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_sr_in    <= 1'b0;
            r_sr_shift <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_ro_en    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state    <= S_LOAD;
                        r_shreg    <= challenge << 1;
                        r_sr_in    <= challenge[CHAL_W-1];
                        r_sr_shift <= 1'b1;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_win_cnt  <= '0;
                        r_rep_cnt  <= '0;
                        r_ones     <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_last_bit) begin
                        r_state    <= S_CLEAR;
                        r_sr_in    <= 1'b0;
                        r_sr_shift <= 1'b0;
                        r_cnt_clr  <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                        r_sr_in   <= r_shreg[CHAL_W-1];
                        r_shreg   <= r_shreg << 1;
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_MEASURE;
                    r_cnt_clr <= 1'b0;
                    r_ro_en   <= 1'b1;
                    r_win_cnt <= '0;
                end
                S_MEASURE: begin
                    if (w_last_win) begin
                        r_state <= S_SAMPLE;
                        r_ro_en <= 1'b0;
                    end else begin
                        r_win_cnt <= r_win_cnt + WW'(1);
                    end
                end
                S_SAMPLE: begin
                    r_ones    <= w_ones_nxt;
                    r_rep_cnt <= r_rep_cnt + RW'(1);
                    if (w_last_rep) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_resp      <= w_resp_nxt;
                        r_resp_ones <= w_ones_nxt;
                    end else begin
                        r_state   <= S_CLEAR;
                        r_cnt_clr <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_sr_in    <= 1'b0;
                    r_sr_shift <= 1'b0;
                    r_cnt_clr  <= 1'b0;
                    r_ro_en    <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign sr_in     = r_sr_in;
    assign sr_shift  = r_sr_shift;
    assign cnt_clr   = r_cnt_clr;
    assign ro_en     = r_ro_en;
    assign done      = r_done;
    assign resp      = r_resp;
    assign resp_ones = r_resp_ones;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: directed and randomized evaluations
// checked cycle by cycle against a timeline model of one evaluation.
module tb_puf_challenge_sequencer;

    localparam int L    = 8;
    localparam int WIN  = 4;
    localparam int REPS = 3;
    localparam int P    = WIN + 2;
    localparam int D    = L + REPS * P + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] challenge = '0;
    logic       ro_bit = 1'b0;
    logic       busy, sr_in, sr_shift, cnt_clr, ro_en, done, resp;
    logic [1:0] resp_ones;

    int tests = 0;
    int fails = 0;
    logic       m_resp = 1'b0;
    logic [1:0] m_ones = '0;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(
        .CHAL_W(L), .WIN_CYCLES(WIN), .REPS(REPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .challenge(challenge), .ro_bit(ro_bit), .busy(busy),
        .sr_in(sr_in), .sr_shift(sr_shift), .cnt_clr(cnt_clr),
        .ro_en(ro_en), .done(done), .resp(resp), .resp_ones(resp_ones)
    );

    function automatic logic [8:0] obs();
        return {busy, sr_in, sr_shift, cnt_clr, ro_en, done, resp, resp_ones};
    endfunction

    // Expected outputs k cycles after an accepted start (start in cycle 0)
    function automatic logic [8:0] exp_vec(int k, logic [7:0] c, int ones,
                                           logic pr, logic [1:0] po);
        logic b, si, sh, cl, re, dn, rs;
        logic [1:0] ro;
        int ph;
        b = 0; si = 0; sh = 0; cl = 0; re = 0; dn = 0;
        rs = pr; ro = po;
        if (k >= 1 && k <= L) begin
            b = 1; sh = 1; si = c[L-k];
        end else if (k > L && k <= L + REPS * P) begin
            b = 1;
            ph = (k - L - 1) % P;
            cl = (ph == 0);
            re = (ph >= 1 && ph <= WIN);
        end else if (k == D) begin
            b = 1; dn = 1;
        end
        if (k >= D) begin
            rs = (2 * ones > REPS);
            ro = 2'(ones);
        end
        return {b, si, sh, cl, re, dn, rs, ro};
    endfunction

    task automatic check(string tag, int k, logic [8:0] o, logic [8:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, o, e);
        end
    endtask

    // kill_at<0: none; kill_rst selects reset vs abort as the kill
    task automatic run(string tag, logic [7:0] c, logic [2:0] bits,
                       int kill_at, bit kill_rst, int sp1, int sp2);
        int ones;
        logic [8:0] e;
        bit smp;
        int r;
        ones = $countones(bits);
        @(posedge clk); #1;
        start = 1; abort = 0; challenge = c; ro_bit = 1'($urandom);
        for (int k = 1; k <= D + 3; k++) begin
            @(posedge clk); #1;
            start = (k == sp1 || k == sp2);
            challenge = start ? 8'hFF : 8'($urandom);
            abort = (!kill_rst && k == kill_at);
            rst_n = !(kill_rst && k == kill_at);
            smp = 0; r = 0;
            for (int i = 0; i < REPS; i++)
                if (k == L + (i + 1) * P) begin smp = 1; r = i; end
            ro_bit = smp ? bits[r] : 1'($urandom);
            @(negedge clk);
            if (kill_at >= 0 && k > kill_at)
                e = kill_rst ? 9'b0 : {7'b0, m_resp, m_ones};
            else
                e = exp_vec(k, c, ones, m_resp, m_ones);
            check(tag, k, obs(), e);
        end
        start = 0; abort = 0; rst_n = 1;
        if (kill_at < 0) begin
            m_resp = (2 * ones > REPS);
            m_ones = 2'(ones);
        end else if (kill_rst) begin
            m_resp = 0;
            m_ones = '0;
        end
    endtask

    initial begin
        // Reset held with start asserted
        rst_n = 0; start = 1; challenge = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("reset", k, obs(), 9'b0);
        end
        @(posedge clk); #1;
        rst_n = 1; start = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_idle", k, obs(), 9'b0);
            @(posedge clk); #1;
        end

        run("full_A5", 8'hA5, 3'b111, -1, 0, -1, -1);
        run("vote_100", 8'($urandom), 3'b001, -1, 0, -1, -1);
        run("vote_011", 8'($urandom), 3'b110, -1, 0, -1, -1);
        run("start_busy", 8'hA5, 3'b111, -1, 0, 5, D);
        run("pre_abort", 8'($urandom), 3'b111, -1, 0, -1, -1);
        run("abort_meas", 8'($urandom), 3'b000, 11, 0, -1, -1);

        // start together with abort in IDLE
        @(posedge clk); #1;
        start = 1; abort = 1; challenge = 8'($urandom);
        @(posedge clk); #1;
        start = 0; abort = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("start_abort_idle", k, obs(), {7'b0, m_resp, m_ones});
            @(posedge clk); #1;
        end

        run("midrun_reset", 8'($urandom), 3'b111, 4, 1, -1, -1);
        run("load_3C", 8'h3C, 3'b010, -1, 0, -1, -1);

        for (int n = 0; n < 6; n++)
            run("random", 8'($urandom), 3'($urandom), -1, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Controller that sequences one RO-PUF evaluation through the challenge shift register and ring-oscillator measurement path. On `start` it shifts a latched challenge MSB-first into the shift register. It then runs `REPS` measurement windows: clear counters, enable ring oscillators, sample the comparator bit. It majority-votes the sampled bits into a single response bit. It sits between the host/UART command logic and the `puf_parallel` datapath, owning the shift register's serial input and all measurement enables.

## Interface
- `CHAL_W`, 8: challenge width, equal to the shift-register length; ≥1
- `WIN_CYCLES`, 1024: measurement window length in `clk` cycles; ≥1
- `REPS`, 3: evaluations per challenge; ≥1, odd recommended

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin evaluation; honoured only in IDLE
- `abort`  in  1  cancel current evaluation
- `challenge`  in  CHAL_W  challenge word, sampled on the accepted `start` cycle
- `ro_bit`  in  1  RO comparator result (1 = RO A faster); sampled in SAMPLE
- `busy`  out  1  high in every state except IDLE
- `sr_in`  out  1  serial data to shift register `in`
- `sr_shift`  out  1  shift-register shift enable
- `cnt_clr`  out  1  RO counter clear, one cycle per repetition
- `ro_en`  out  1  ring-oscillator/counter enable during the window
- `done`  out  1  one-cycle pulse when `resp` is updated
- `resp`  out  1  majority-voted response; holds until next `done`
- `resp_ones`  out  $clog2(REPS+1)  count of `ro_bit`=1 samples in the last completed evaluation

## Operation
- State machine: IDLE → LOAD → CLEAR → MEASURE → SAMPLE → (CLEAR if reps remain, else DONE) → IDLE.
- IDLE:
  - On `start`=1 and `abort`=0: latch `challenge` into a shift copy, clear bit/window/rep/ones counters, go to LOAD.
  - `abort`=1 in IDLE: no effect, and `start` is ignored that cycle.
- LOAD: exactly CHAL_W cycles.
  - `sr_shift`=1.
  - `sr_in` = challenge bit CHAL_W-1 on the first cycle, then descending to bit 0 on the last.
- CLEAR: 1 cycle, `cnt_clr`=1.
- MEASURE: exactly WIN_CYCLES cycles, `ro_en`=1.
- SAMPLE: 1 cycle, all enables 0.
  - Increment the ones counter if `ro_bit`=1.
  - Increment the rep counter.
  - Go to CLEAR if reps remain, else DONE.
- DONE: 1 cycle.
  - `done`=1.
  - `resp` = (2·ones > REPS); ties resolve to 0.
  - `resp_ones` = ones. Both outputs register on entry so they are valid while `done`=1.
- Outside the states above, `sr_shift`, `sr_in`, `cnt_clr` and `ro_en` are 0.
- `start` while `busy`=1, including the DONE cycle, is ignored and not queued.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE.
  - All enables drop on the following edge.
  - No `done` pulse; `resp` and `resp_ones` keep their prior values.
  - Abort in DONE is too late: that `done` still completes.
- Counter widths: the bit counter is sized for CHAL_W, the window counter for WIN_CYCLES, and the rep/ones counters for REPS. None wraps in legal operation.

## Timing
- All outputs are registered or decoded from registered state; no combinational input→output paths.
- Reset (`rst_n`=0 at an edge): state IDLE, and every output, including `resp` and `resp_ones`, is 0 after that edge. This applies mid-operation as well.
- Accepted `start` at cycle 0:
  - LOAD occupies cycles 1..CHAL_W.
  - Each repetition takes WIN_CYCLES+2 cycles.
  - `done` is high at cycle CHAL_W + REPS·(WIN_CYCLES+2) + 1.
  - `busy` is high from cycle 1 through the `done` cycle.
- The earliest next `start` is accepted in the cycle after `done`.
- `ro_bit` must be stable in the SAMPLE cycle, i.e. one cycle after the last `ro_en`=1 cycle.

## Test plan
Bench parameters: CHAL_W=8, WIN_CYCLES=4, REPS=3.

1. Reset:
   - Stimulus: hold `rst_n`=0 for 3 cycles with `start`=1.
   - Required: all outputs 0, `busy`=0. Release; still IDLE until a fresh `start`.
2. Full evaluation:
   - Stimulus: `start` with `challenge`=8'hA5, `ro_bit`=1 constant.
   - Required: `sr_shift` high cycles 1–8 with `sr_in`=1,0,1,0,0,1,0,1.
   - Required: `cnt_clr` pulses at cycles 9, 15, 21; `ro_en` high for 4 cycles after each.
   - Required: `done` at cycle 27, `resp`=1, `resp_ones`=3.
3. Majority vote:
   - Stimulus: `ro_bit`=1,0,0 across the three SAMPLE cycles.
   - Required: `resp`=0, `resp_ones`=1.
   - Stimulus: `ro_bit`=0,1,1.
   - Required: `resp`=1, `resp_ones`=2.
4. Start while busy:
   - Stimulus: pulse `start` with `challenge`=8'hFF at cycles 5 and 27 of a run.
   - Required: both pulses ignored; the `sr_in` sequence and `done` timing match scenario 2, and there is no second run.
5. Abort:
   - Stimulus: `abort` at cycle 11 (MEASURE) after a completed `resp`=1 run.
   - Required: `ro_en`=0 from cycle 12, `busy`=0, no `done`, `resp`=1 retained.
   - Stimulus: `start` and `abort` together in IDLE.
   - Required: no run.
6. Mid-run reset:
   - Stimulus: `rst_n`=0 at cycle 4 (LOAD).
   - Required: `sr_shift`, `sr_in`, `busy`, `resp`, `resp_ones` all 0 after that edge. A new `start` with 8'h3C then shifts 0,0,1,1,1,1,0,0.
